dsc_mul_ctrl: RTL and testbench

//  Sequencer that sits directly upstream/downstream of the 2-input deterministic stochastic multiplier core.

---
 rtl/dsc_mul_ctrl_pkg.sv | 17 +
 rtl/dsc_mul_ctrl_cnt.sv | 41 ++++
 rtl/dsc_mul_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dsc_mul_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_mul_ctrl_pkg.sv
// Shared definitions for the deterministic stochastic multiplier sequencer.
// Holds the default operand geometry and the 3-bit binary FSM state encoding
// that the sequencer top and the bench both refer to.
package dsc_mul_ctrl_pkg;

  localparam int SNG_WIDTH_DEF  = 10;
  localparam int NUM_INPUTS_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/dsc_mul_ctrl_cnt.sv
// Parameterised up-counter with synchronous clear and saturation.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (count -> 0)
//   clr  synchronous clear, has priority over en
//   en   count enable; the count stops at MAX and never wraps
//   cnt  current count
module dsc_mul_ctrl_cnt #(
  parameter int               WIDTH = 21,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dsc_mul_ctrl.sv
// Sequencer around the 2-input deterministic stochastic multiplier core.
// Takes one operand pair per in_valid/in_ready handshake, clears the core,
// runs it until mul_ov (or the run-length watchdog) ends the run, lets the
// core counter settle for one cycle, captures the product and presents it on
// the out_valid/out_ready port together with the number of RUN cycles used.
// A zero operand skips the core entirely and returns a zero product.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        operand handshake; in_ready only while idle
//   in_a, in_b               unsigned fractional operands
//   mul_a, mul_b             registered operands to the core
//   mul_rst, mul_en          core clear (active-high) and enable
//   mul_z, mul_ov            core product count and done/shutoff flag
//   out_valid/out_ready      result handshake
//   out_z                    captured product
//   out_cycles               RUN cycles used (0 on bypass)
//   out_timeout              run ended by the watchdog rather than mul_ov
module dsc_mul_ctrl
  import dsc_mul_ctrl_pkg::*;
#(
  parameter int SNG_WIDTH  = SNG_WIDTH_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int OUT_WIDTH  = NUM_INPUTS * SNG_WIDTH,
  parameter int MAX_RUN    = 2 ** OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] in_a,
  input  logic [SNG_WIDTH-1:0] in_b,
  output logic [SNG_WIDTH-1:0] mul_a,
  output logic [SNG_WIDTH-1:0] mul_b,
  output logic                 mul_rst,
  output logic                 mul_en,
  input  logic [OUT_WIDTH-1:0] mul_z,
  input  logic                 mul_ov,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_z,
  output logic [OUT_WIDTH:0]   out_cycles,
  output logic                 out_timeout
);

  localparam int             CNT_W      = OUT_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_RUN_V  = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] MAX_RUN_M1 = CNT_W'(MAX_RUN - 1);

  state_e               state_q,       state_d;
  logic                 in_ready_q,    in_ready_d;
  logic [SNG_WIDTH-1:0] mul_a_q,       mul_a_d;
  logic [SNG_WIDTH-1:0] mul_b_q,       mul_b_d;
  logic                 mul_rst_q,     mul_rst_d;
  logic                 mul_en_q,      mul_en_d;
  logic                 out_valid_q,   out_valid_d;
  logic [OUT_WIDTH-1:0] out_z_q,       out_z_d;
  logic [CNT_W-1:0]     out_cycles_q,  out_cycles_d;
  logic                 out_timeout_q, out_timeout_d;
  logic                 timeout_q,     timeout_d;
  logic                 bypass_q,      bypass_d;

  logic [CNT_W-1:0]     run_cnt;
  logic                 cnt_clr;
  logic                 cnt_en;

  assign cnt_clr = (state_q == ST_CLR);
  assign cnt_en  = (state_q == ST_RUN);

  // The count seen in DRAIN equals the number of RUN cycles just completed.
  dsc_mul_ctrl_cnt #(
    .WIDTH (CNT_W),
    .MAX   (MAX_RUN_V)
  ) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (run_cnt)
  );

  always_comb begin
    state_d       = state_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    out_z_d       = out_z_q;
    out_cycles_d  = out_cycles_q;
    out_timeout_d = out_timeout_q;
    timeout_d     = timeout_q;
    bypass_d      = bypass_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mul_a_d   = in_a;
          mul_b_d   = in_b;
          timeout_d = 1'b0;
          // A zero operand borrows the one-cycle DRAIN slot instead of the
          // core, so its (zero) result still appears one edge after accept.
          if ((in_a == '0) || (in_b == '0)) begin
            bypass_d = 1'b1;
            state_d  = ST_DRAIN;
          end else begin
            bypass_d = 1'b0;
            state_d  = ST_CLR;
          end
        end
      end
      ST_CLR: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // run_cnt lags by one: it reads k-1 during the k-th RUN cycle, so the
        // watchdog trips on the edge where the count reaches MAX_RUN.
        if (mul_ov) begin
          timeout_d = 1'b0;
          state_d   = ST_DRAIN;
        end else if (run_cnt == MAX_RUN_M1) begin
          timeout_d = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bypass_q) begin
          out_z_d       = '0;
          out_cycles_d  = '0;
          out_timeout_d = 1'b0;
        end else begin
          out_z_d       = mul_z;
          out_cycles_d  = run_cnt;
          out_timeout_d = timeout_q;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Port controls are registered from the next state so they line up
    // exactly with the state they belong to.
    in_ready_d  = (state_d == ST_IDLE);
    mul_en_d    = (state_d == ST_RUN);
    out_valid_d = (state_d == ST_HOLD);
    // The core stays cleared except while running and while its counter
    // settles after a real run.
    mul_rst_d   = !((state_d == ST_RUN) || ((state_d == ST_DRAIN) && !bypass_d));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_rst_q     <= 1'b1;
      mul_en_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_z_q       <= '0;
      out_cycles_q  <= '0;
      out_timeout_q <= 1'b0;
      timeout_q     <= 1'b0;
      bypass_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_rst_q     <= mul_rst_d;
      mul_en_q      <= mul_en_d;
      out_valid_q   <= out_valid_d;
      out_z_q       <= out_z_d;
      out_cycles_q  <= out_cycles_d;
      out_timeout_q <= out_timeout_d;
      timeout_q     <= timeout_d;
      bypass_q      <= bypass_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_rst     = mul_rst_q;
  assign mul_en      = mul_en_q;
  assign out_valid   = out_valid_q;
  assign out_z       = out_z_q;
  assign out_cycles  = out_cycles_q;
  assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Bench for dsc_mul_ctrl: a default-width instance and a SNG_WIDTH=2
// instance (MAX_RUN=16), each driving a behavioural core stub whose ov delay
// and z value are programmable. Expected results are queued at issue time and
// popped by per-instance monitors on each result handshake.
module tb_dsc_mul_ctrl;

  typedef struct {
    logic [19:0] z;
    logic [20:0] cyc;
    logic        to;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  // default instance signals
  logic        in_valid, in_ready, mul_rst, mul_en, mul_ov, out_valid, out_ready, out_timeout;
  logic [9:0]  in_a, in_b, mul_a, mul_b;
  logic [19:0] z_m, out_z;
  logic [20:0] out_cycles;
  int          dly_m = 0;
  int          en_cnt_m = 0;

  // narrow instance signals
  logic        w_in_valid, w_in_ready, w_mul_rst, w_mul_en, w_mul_ov, w_out_valid, w_out_ready, w_out_timeout;
  logic [1:0]  w_in_a, w_in_b, w_mul_a, w_mul_b;
  logic [3:0]  z_w, w_out_z;
  logic [4:0]  w_out_cycles;
  int          dly_w = 0;
  int          en_cnt_w = 0;

  exp_t sb_m[$];
  exp_t sb_w[$];
  exp_t e_m, e_w;
  int   rise_m = 0, rise_w = 0;
  bit   pv_m = 0, pv_w = 0;
  bit   en_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsc_mul_ctrl u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rst(mul_rst), .mul_en(mul_en), .mul_z(z_m), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_cycles(out_cycles),
    .out_timeout(out_timeout)
  );

  dsc_mul_ctrl #(.SNG_WIDTH(2)) u_dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
    .mul_a(w_mul_a), .mul_b(w_mul_b), .mul_rst(w_mul_rst), .mul_en(w_mul_en), .mul_z(z_w),
    .mul_ov(w_mul_ov), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_z(w_out_z),
    .out_cycles(w_out_cycles), .out_timeout(w_out_timeout)
  );

  // Core stubs: count enabled cycles since the last clear; ov on the dly-th one.
  always @(posedge clk) begin
    if (mul_rst) en_cnt_m <= 0;
    else if (mul_en) en_cnt_m <= en_cnt_m + 1;
    if (w_mul_rst) en_cnt_w <= 0;
    else if (w_mul_en) en_cnt_w <= en_cnt_w + 1;
  end
  assign mul_ov   = (dly_m != 0) && mul_en && (en_cnt_m == dly_m - 1);
  assign w_mul_ov = (dly_w != 0) && w_mul_en && (en_cnt_w == dly_w - 1);

  always @(negedge clk) if (mul_en === 1'b1) en_seen = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on each result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      pv_m = 1'b0;
    end else begin
      if (out_valid && !pv_m) rise_m = cyc;
      pv_m = out_valid;
      if (out_valid && out_ready) begin
        if (sb_m.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_result: got out_valid=1 expected no result pending");
        end else begin
          e_m = sb_m.pop_front();
          chk("out_z", 64'(out_z), 64'(e_m.z));
          chk("out_cycles", 64'(out_cycles), 64'(e_m.cyc));
          chk("out_timeout", 64'(out_timeout), 64'(e_m.to));
          chk("latency", 64'(rise_m - e_m.acc), 64'(e_m.lat));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      pv_w = 1'b0;
    end else begin
      if (w_out_valid && !pv_w) rise_w = cyc;
      pv_w = w_out_valid;
      if (w_out_valid && w_out_ready) begin
        if (sb_w.size() == 0) begin
          checks++; errs++;
          $display("FAIL w_unexpected_result: got out_valid=1 expected no result pending");
        end else begin
          e_w = sb_w.pop_front();
          chk("w_out_z", 64'(w_out_z), 64'(e_w.z));
          chk("w_out_cycles", 64'(w_out_cycles), 64'(e_w.cyc));
          chk("w_out_timeout", 64'(w_out_timeout), 64'(e_w.to));
          chk("w_latency", 64'(rise_w - e_w.acc), 64'(e_w.lat));
        end
      end
    end
  end

  task automatic issue(input logic [9:0] a, input logic [9:0] b, input int dly, input logic [19:0] z,
                       input bit push, input logic [19:0] ez, input logic [20:0] ec, input bit eto,
                       input int lat);
    int   n;
    exp_t x;
    in_a = a; in_b = b; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin
      errs++;
      $display("FAIL accept: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      dly_m = dly; z_m = z;
      if (push) begin
        x.z = ez; x.cyc = ec; x.to = eto; x.lat = lat; x.acc = cyc + 1;
        sb_m.push_back(x);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic issue_w(input logic [1:0] a, input logic [1:0] b, input int dly, input logic [3:0] z,
                         input logic [3:0] ez, input logic [4:0] ec, input bit eto, input int lat);
    int   n;
    exp_t x;
    w_in_a = a; w_in_b = b; w_in_valid = 1'b1; n = 0;
    while (!w_in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!w_in_ready) begin
      errs++;
      $display("FAIL w_accept: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      dly_w = dly; z_w = z;
      x.z = 20'(ez); x.cyc = 21'(ec); x.to = eto; x.lat = lat; x.acc = cyc + 1;
      sb_w.push_back(x);
    end
    @(posedge clk); #1 w_in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((sb_m.size() != 0 || sb_w.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(sb_m.size() + sb_w.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; z_m = '0;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b1; z_w = '0;

    // 1: reset held 3 cycles with inputs toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_a = in_a + 10'd37; in_b = in_b + 10'd91;
      w_in_valid = ~w_in_valid; w_in_a = w_in_a + 2'd1;
    end
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mul_rst", 64'(mul_rst), 64'd1);
    chk("rst_mul_en", 64'(mul_en), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_z", 64'(out_z), 64'd0);
    chk("rst_out_cycles", 64'(out_cycles), 64'd0);
    chk("rst_out_timeout", 64'(out_timeout), 64'd0);
    chk("rst_w_in_ready", 64'(w_in_ready), 64'd0);
    in_valid = 1'b0; w_in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 2: normal run, ov on 5th RUN cycle
    issue(10'd512, 10'd512, 5, 20'h00123, 1'b1, 20'h00123, 21'd5, 1'b0, 7);
    wait_empty();

    // 3: zero-operand bypass; stub z nonzero must not leak through
    en_seen = 1'b0;
    issue(10'd0, 10'd700, 3, 20'h00777, 1'b1, 20'h0, 21'd0, 1'b0, 1);
    wait_empty();
    chk("bypass_mul_en_seen", 64'(en_seen), 64'd0);

    // 4: watchdog on the narrow instance, then ov and watchdog on the same edge
    issue_w(2'd2, 2'd3, 0, 4'h9, 4'h9, 5'd16, 1'b1, 18);
    wait_empty();
    issue_w(2'd1, 2'd3, 16, 4'h5, 4'h5, 5'd16, 1'b0, 18);
    wait_empty();

    // 5: backpressure in HOLD; a busy in_valid must be ignored
    out_ready = 1'b0;
    issue(10'd3, 10'd5, 2, 20'h00456, 1'b1, 20'h00456, 21'd2, 1'b0, 4);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_out_valid_rise", 64'(out_valid), 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_state", {out_valid, in_ready, out_timeout, out_z, out_cycles},
          {1'b1, 1'b0, 1'b0, 20'h00456, 21'd2});
      if (i == 3) begin in_valid = 1'b1; in_a = 10'd11; in_b = 10'd13; end
      if (i == 6) in_valid = 1'b0;
    end
    chk("bp_ignored_mul_a", 64'(mul_a), 64'd3);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});
    issue(10'd20, 10'd30, 1, 20'h0BEEF, 1'b1, 20'h0BEEF, 21'd1, 1'b0, 3);
    wait_empty();

    // 6: reset during the 3rd RUN cycle aborts the in-flight pair
    issue(10'd100, 10'd200, 20, 20'h00999, 1'b0, 20'h0, 21'd0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_mul_en", 64'(mul_en), 64'd0);
    chk("abort_mul_rst", 64'(mul_rst), 64'd1);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_mul_a", 64'(mul_a), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_result", {out_valid, out_z, out_cycles}, 64'd0);
    issue(10'd7, 10'd9, 3, 20'h0ABCD, 1'b1, 20'h0ABCD, 21'd3, 1'b0, 5);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
